// File: rtl/bk_pulse_pkg.sv
// Shared definitions for the bk_pulse_gen breakdown-test pulse generator:
// channel state encoding, default counter widths, the legacy 876/250000
// pattern constants, and the width of the optional pulse statistics counter.
package bk_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } bk_state_e;

    localparam int BK_CNT_W   = 19;
    localparam int BK_NP_W    = 8;
    localparam int BK_DEF_WID = 876;
    localparam int BK_DEF_PER = 250000;
    localparam int BK_STAT_W  = 16;

endpackage

// File: rtl/bk_pulse_chan.sv
// One pulse-generator channel: IDLE/HIGH/LOW/GAP state machine, phase and
// pulse counters, and the configuration captured at start.
// Optional feature: BK_PULSE_STATS_EN adds a saturating count of rising
// edges on the pulse output.
module bk_pulse_chan
    import bk_pulse_pkg::*;
#(
    parameter int CNT_W   = BK_CNT_W,
    parameter int NP_W    = BK_NP_W,
    parameter int DEF_WID = BK_DEF_WID,
    parameter int DEF_PER = BK_DEF_PER
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             repeat_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [NP_W-1:0]  npulse_i,
    input  logic [CNT_W-1:0] gap_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
`ifdef BK_PULSE_STATS_EN
    ,
    output logic [BK_STAT_W-1:0] pulse_cnt_o
`endif
);

    bk_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NP_W-1:0]  pcnt_q, pcnt_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Captured configuration; low_q holds period-width so the LOW phase
    // needs no subtraction on the fly.
    logic [CNT_W-1:0] wid_q, low_q, gap_q;
    logic [NP_W-1:0]  npulse_q;
    logic             rep_q;
    logic             cfg_load;

    logic             cfg_valid;
    logic             high_end, low_end, gap_end;
    logic [NP_W:0]    pcnt_next;

    assign cfg_valid = (width_i != '0) && (width_i < period_i);
    assign high_end  = (cnt_q == wid_q - 1'b1);
    assign low_end   = (cnt_q == low_q - 1'b1);
    assign gap_end   = (cnt_q == gap_q - 1'b1);
    assign pcnt_next = {1'b0, pcnt_q} + 1'b1;

    // Next-state, counter and strobe logic for the channel FSM.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        pcnt_d   = pcnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cfg_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i && !stop_i) begin
                    if (cfg_valid) begin
                        cfg_load = 1'b1;
                        pcnt_d   = '0;
                        state_d  = ST_HIGH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (high_end) begin
                    cnt_d   = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (low_end) begin
                    cnt_d = '0;
                    if (npulse_q == '0) begin
                        // Continuous mode: the pulse count is irrelevant.
                        state_d = ST_HIGH;
                    end else if (pcnt_next < {1'b0, npulse_q}) begin
                        pcnt_d  = pcnt_next[NP_W-1:0];
                        state_d = ST_HIGH;
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                    end else if (rep_q) begin
                        pcnt_d  = '0;
                        state_d = ST_HIGH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    cnt_d = '0;
                    if (rep_q) begin
                        pcnt_d  = '0;
                        state_d = ST_HIGH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything and never reports completion.
        if (stop_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign pulse_d = (state_d == ST_HIGH);

    // State, counters, output registers and captured configuration.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wid_q    <= CNT_W'(DEF_WID);
            low_q    <= CNT_W'(DEF_PER - DEF_WID);
            npulse_q <= NP_W'(1);
            gap_q    <= '0;
            rep_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (cfg_load) begin
                wid_q    <= width_i;
                low_q    <= period_i - width_i;
                npulse_q <= npulse_i;
                gap_q    <= gap_i;
                rep_q    <= repeat_i;
            end
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;

`ifdef BK_PULSE_STATS_EN
    logic [BK_STAT_W-1:0] stat_q;

    // Saturating count of rising edges seen on the registered pulse output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else if (pulse_d && !pulse_q && (stat_q != '1)) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign pulse_cnt_o = stat_q;
`endif

endmodule

// File: rtl/bk_pulse_gen.sv
// Multi-channel programmable breakdown-test pulse generator (25 MHz domain).
// Instantiates CH independent bk_pulse_chan channels sharing one set of
// configuration inputs; each channel captures them only on its own start.
// Optional feature: BK_PULSE_STATS_EN adds o_pulse_cnt, 16 bits per channel.
module bk_pulse_gen
    import bk_pulse_pkg::*;
#(
    parameter int CH      = 4,
    parameter int CNT_W   = BK_CNT_W,
    parameter int NP_W    = BK_NP_W,
    parameter int DEF_WID = BK_DEF_WID,
    parameter int DEF_PER = BK_DEF_PER
) (
    input  logic             i_clk_25m,
    input  logic             i_rst_n,
    input  logic [CH-1:0]    i_start,
    input  logic [CH-1:0]    i_stop,
    input  logic             i_repeat,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_period,
    input  logic [NP_W-1:0]  i_npulse,
    input  logic [CNT_W-1:0] i_gap,
    output logic [CH-1:0]    o_bk_pulse,
    output logic [CH-1:0]    o_busy,
    output logic [CH-1:0]    o_done,
    output logic [CH-1:0]    o_err
`ifdef BK_PULSE_STATS_EN
    ,
    output logic [CH*BK_STAT_W-1:0] o_pulse_cnt
`endif
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        bk_pulse_chan #(
            .CNT_W   (CNT_W),
            .NP_W    (NP_W),
            .DEF_WID (DEF_WID),
            .DEF_PER (DEF_PER)
        ) u_chan (
            .clk_i    (i_clk_25m),
            .rst_ni   (i_rst_n),
            .start_i  (i_start[g]),
            .stop_i   (i_stop[g]),
            .repeat_i (i_repeat),
            .width_i  (i_width),
            .period_i (i_period),
            .npulse_i (i_npulse),
            .gap_i    (i_gap),
            .pulse_o  (o_bk_pulse[g]),
            .busy_o   (o_busy[g]),
            .done_o   (o_done[g]),
            .err_o    (o_err[g])
`ifdef BK_PULSE_STATS_EN
            ,
            .pulse_cnt_o (o_pulse_cnt[g*BK_STAT_W +: BK_STAT_W])
`endif
        );
    end

endmodule

// File: tb/tb_bk_pulse_gen.sv
// Self-checking bench for bk_pulse_gen: table-driven config validation,
// hand-written multi-cycle sequences, and randomized traffic compared every
// cycle against a schedule-based reference model.
module tb_bk_pulse_gen;

    localparam int CH    = 4;
    localparam int CNT_W = 19;
    localparam int NP_W  = 8;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    start, stop;
    logic             rep;
    logic [CNT_W-1:0] width, period, gap;
    logic [NP_W-1:0]  npulse;
    logic [CH-1:0]    o_bk_pulse, o_busy, o_done, o_err;
`ifdef BK_PULSE_STATS_EN
    logic [CH*16-1:0] o_pulse_cnt;
`endif

    bk_pulse_gen #(.CH(CH), .CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .i_clk_25m  (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_stop     (stop),
        .i_repeat   (rep),
        .i_width    (width),
        .i_period   (period),
        .i_npulse   (npulse),
        .i_gap      (gap),
        .o_bk_pulse (o_bk_pulse),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
`ifdef BK_PULSE_STATS_EN
        ,
        .o_pulse_cnt (o_pulse_cnt)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each active channel tracks t = cycles since its first HIGH cycle; the
    // output is computed from the burst schedule with plain arithmetic.
    bit          m_act [CH];
    longint      m_t   [CH];
    longint      m_w   [CH];
    longint      m_p   [CH];
    longint      m_n   [CH];
    longint      m_g   [CH];
    bit          m_r   [CH];
    int          m_cnt [CH];
    logic [CH-1:0] m_pulse, m_busy, m_done, m_err;

    function automatic bit m_high(input int ch);
        longint pos;
        longint burst;
        if (m_n[ch] == 0) begin
            pos = m_t[ch] % m_p[ch];
        end else begin
            burst = m_n[ch] * m_p[ch] + m_g[ch];
            pos   = m_r[ch] ? (m_t[ch] % burst) : m_t[ch];
            if (pos >= m_n[ch] * m_p[ch]) return 1'b0;
            pos = pos % m_p[ch];
        end
        return pos < m_w[ch];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_act[c] = 1'b0;
                m_t[c]   = 0;
                m_cnt[c] = 0;
            end
            m_pulse = '0; m_busy = '0; m_done = '0; m_err = '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit newp;
                m_done[c] = 1'b0;
                m_err[c]  = 1'b0;
                if (m_act[c]) begin
                    if (stop[c]) begin
                        m_act[c] = 1'b0;
                    end else begin
                        m_t[c]++;
                        if (!m_r[c] && m_n[c] != 0 && m_t[c] == m_n[c] * m_p[c] + m_g[c]) begin
                            m_act[c]  = 1'b0;
                            m_done[c] = 1'b1;
                        end
                    end
                end else if (start[c] && !stop[c]) begin
                    if (width != 0 && width < period) begin
                        m_act[c] = 1'b1;
                        m_t[c]   = 0;
                        m_w[c]   = longint'(width);
                        m_p[c]   = longint'(period);
                        m_n[c]   = longint'(npulse);
                        m_g[c]   = longint'(gap);
                        m_r[c]   = rep;
                    end else begin
                        m_err[c] = 1'b1;
                    end
                end
                m_busy[c] = m_act[c];
                newp = m_act[c] && m_high(c);
                if (newp && !m_pulse[c] && m_cnt[c] < 65535) m_cnt[c]++;
                m_pulse[c] = newp;
            end
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pulse", 64'(o_bk_pulse), 64'(m_pulse));
            check("model_busy",  64'(o_busy),     64'(m_busy));
            check("model_done",  64'(o_done),     64'(m_done));
            check("model_err",   64'(o_err),      64'(m_err));
`ifdef BK_PULSE_STATS_EN
            for (int c = 0; c < CH; c++)
                check("model_stats", 64'(o_pulse_cnt[c*16 +: 16]), 64'(m_cnt[c]));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive strobes and shared config for one cycle; returns one tick later.
    task automatic strobe(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                          input int w, input int p, input int n, input int g, input logic r);
        start  = st;
        stop   = sp;
        width  = CNT_W'(w);
        period = CNT_W'(p);
        npulse = NP_W'(n);
        gap    = CNT_W'(g);
        rep    = r;
        @(posedge clk);
        #1;
        start = '0;
        stop  = '0;
    endtask

    typedef struct {
        int   w;
        int   p;
        int   n;
        logic exp_err;
        logic exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  hi_cnt;
        bit  saw_done;
        logic exp_hi;

        vecs[0] = '{w: 8, p: 8,  n: 1, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{w: 0, p: 8,  n: 1, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{w: 9, p: 8,  n: 1, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{w: 7, p: 8,  n: 1, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{w: 1, p: 2,  n: 0, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{w: 0, p: 0,  n: 3, exp_err: 1'b1, exp_busy: 1'b0};

        rst_n = 1'b0;
        start = '0; stop = '0; rep = 1'b0;
        width = '0; period = '0; npulse = '0; gap = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_pulse", 64'(o_bk_pulse), 64'd0);
        check("reset_busy",  64'(o_busy),     64'd0);
        check("reset_done",  64'(o_done),     64'd0);
        check("reset_err",   64'(o_err),      64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cycles(2);

        // One-shot burst on ch0: width 3, period 8, two pulses, gap 5
        strobe(4'b0001, 4'b0000, 3, 8, 2, 5, 1'b0);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            exp_hi = ((c >= 1 && c <= 3) || (c >= 9 && c <= 11));
            check("burst_pulse", 64'(o_bk_pulse[0]), 64'(exp_hi));
            check("burst_busy",  64'(o_busy[0]),     64'(c <= 21));
            check("burst_done",  64'(o_done[0]),     64'(c == 22));
            @(posedge clk);
            #1;
        end
`ifdef BK_PULSE_STATS_EN
        check("stats_after_burst", 64'(o_pulse_cnt[15:0]), 64'd2);
`endif
        cycles(2);

        // Config validation table on ch2
        for (int i = 0; i < 6; i++) begin
            strobe(4'b0100, 4'b0000, vecs[i].w, vecs[i].p, vecs[i].n, 0, 1'b0);
            @(negedge clk);
            check("vec_err",  64'(o_err[2]),  64'(vecs[i].exp_err));
            check("vec_busy", 64'(o_busy[2]), 64'(vecs[i].exp_busy));
            @(posedge clk);
            #1;
            strobe(4'b0000, 4'b0100, 0, 0, 0, 0, 1'b0);
            @(negedge clk);
            check("vec_err_clear",  64'(o_err[2]),  64'd0);
            check("vec_busy_clear", 64'(o_busy[2]), 64'd0);
            @(posedge clk);
            #1;
        end

        // Abort mid-HIGH on ch0
        strobe(4'b0001, 4'b0000, 5, 10, 0, 0, 1'b0);
        cycles(2);
        strobe(4'b0000, 4'b0001, 5, 10, 0, 0, 1'b0);
        @(negedge clk);
        check("stop_pulse", 64'(o_bk_pulse[0]), 64'd0);
        check("stop_busy",  64'(o_busy[0]),     64'd0);
        check("stop_done",  64'(o_done[0]),     64'd0);
        @(posedge clk);
        #1;
        // Start and stop in the same cycle: stays IDLE, no error
        strobe(4'b0001, 4'b0001, 2, 4, 0, 0, 1'b0);
        @(negedge clk);
        check("startstop_busy", 64'(o_busy[0]), 64'd0);
        check("startstop_err",  64'(o_err[0]),  64'd0);
        @(posedge clk);
        #1;
        // Start while busy is ignored (model verifies the original pattern)
        strobe(4'b0001, 4'b0000, 2, 4, 0, 0, 1'b0);
        cycles(1);
        strobe(4'b0001, 4'b0000, 3, 6, 0, 0, 1'b0);
        @(negedge clk);
        check("busy_start_err", 64'(o_err[0]), 64'd0);
        @(posedge clk);
        #1;
        cycles(12);
        strobe(4'b0000, 4'b0001, 0, 0, 0, 0, 1'b0);
        cycles(2);

        // Legacy pattern on ch1, continuous
        strobe(4'b0010, 4'b0000, 876, 250000, 0, 0, 1'b0);
        hi_cnt   = 0;
        saw_done = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (o_bk_pulse[1]) hi_cnt++;
            if (o_done[1]) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("legacy_high_cycles", 64'(hi_cnt),    64'd876);
        check("legacy_no_done",     64'(saw_done),  64'd0);
        check("legacy_busy",        64'(o_busy[1]), 64'd1);
        strobe(4'b0000, 4'b0010, 0, 0, 0, 0, 1'b0);
        cycles(2);

        // Repeating burst on ch0, independent one-shot on ch3 one cycle later
        strobe(4'b0001, 4'b0000, 2, 4, 1, 3, 1'b1);
        for (int c = 1; c <= 21; c++) begin
            if (c == 1) begin
                start = 4'b1000; width = 19'd1; period = 19'd3;
                npulse = 8'd2; gap = 19'd2; rep = 1'b0;
            end
            @(negedge clk);
            check("repeat_pulse", 64'(o_bk_pulse[0]), 64'(((c - 1) % 7) < 2));
            @(posedge clk);
            #1;
            start = '0;
        end
        // Async reset while ch0 is high
        check("pre_reset_pulse", 64'(o_bk_pulse[0]), 64'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", 64'(o_bk_pulse), 64'd0);
        check("async_rst_busy",  64'(o_busy),     64'd0);
        check("async_rst_done",  64'(o_done),     64'd0);
        check("async_rst_err",   64'(o_err),      64'd0);
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(o_busy), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c]  = ($urandom_range(0, 79) == 0);
            end
            width  = CNT_W'($urandom_range(0, 6));
            period = CNT_W'($urandom_range(0, 10));
            npulse = NP_W'($urandom_range(0, 4));
            gap    = CNT_W'($urandom_range(0, 5));
            rep    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        start = '0;
        stop  = '0;
        cycles(4);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
